ula_exec_stage: RTL

Two-entry execute pipeline wrapped around the 32-bit ALU of the Lapido processor. It accepts decoded operands, opcode and destination register from the operand-fetch stage over a valid/ready handshake. It drives the ALU from registered inputs, computes the N/Z/C/V flags, and presents result, destination and flags to write-back over a second valid/ready handshake. It also keeps the architectural flags register.

---
 rtl/lapido_alu_pkg.sv | 32 +++
 rtl/ula_flag_gen.sv | 62 ++++++
 rtl/ula_exec_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/lapido_alu_pkg.sv
// Lapido ALU shared definitions: opcode encodings, flag bit positions, opcode classifiers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lapido_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADDINC = 5'b00001;
    localparam logic [4:0] OP_INCA   = 5'b00011;
    localparam logic [4:0] OP_SUBDEC = 5'b00100;
    localparam logic [4:0] OP_SUB    = 5'b00101;
    localparam logic [4:0] OP_DECA   = 5'b00110;
    localparam logic [4:0] OP_LSL    = 5'b01000;
    localparam logic [4:0] OP_ASR    = 5'b01001;

    // Bit positions inside a {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Carry-chain opcodes: their C/V come from the 33-bit adder
    function automatic logic is_arith_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADDINC) || (op == OP_INCA) ||
               (op == OP_SUBDEC) || (op == OP_SUB) || (op == OP_DECA);
    endfunction

    // Whole upper half of the opcode space is the logic-op group
    function automatic logic is_legal_op(input logic [4:0] op);
        return op[4] || is_arith_op(op) || (op == OP_LSL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/ula_flag_gen.sv
// N/Z/C/V generation for the beat in stage E from its operands, opcode and the ALU result.
// Latency: combinational.
// Backpressure: none; outputs follow the registered ALU inputs.
// Ports: a/b operands, opcode, res (ALU result) in; nzcv flag nibble out.
module ula_flag_gen
    import lapido_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] res,
    output logic [3:0]        nzcv
);

    logic [DATA_W-1:0] b_sel;
    logic              cin;
    logic [DATA_W:0]   sum;
    logic              carry;
    logic              ovf;

    always_comb begin
        b_sel = b;
        cin   = 1'b0;
        case (opcode)
            OP_ADDINC: cin = 1'b1;
            OP_INCA: begin
                b_sel = '0;
                cin   = 1'b1;
            end
            OP_SUBDEC: b_sel = ~b;
            OP_SUB: begin
                b_sel = ~b;
                cin   = 1'b1;
            end
            OP_DECA: b_sel = '1;
            default: ;
        endcase

        sum = {1'b0, a} + {1'b0, b_sel} + {{DATA_W{1'b0}}, cin};

        carry = 1'b0;
        ovf   = 1'b0;
        if (is_arith_op(opcode)) begin
            // Only the carry-out of the adder matters; the sum itself comes from the ALU
            carry = (sum >> DATA_W) != '0;
            ovf   = (a[DATA_W-1] == b_sel[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        end else if (opcode == OP_LSL) begin
            carry = a[DATA_W-1];
        end else if (opcode == OP_ASR) begin
            carry = a[0];
        end

        nzcv         = '0;
        nzcv[FLAG_N] = res[DATA_W-1];
        nzcv[FLAG_Z] = (res == '0);
        nzcv[FLAG_C] = carry;
        nzcv[FLAG_V] = ovf;
    end

endmodule

// File: rtl/ula_exec_stage.sv
// Two-entry execute pipeline (E holds operands for the external ALU, W holds result+flags) plus architectural flags.
// Latency: beat accepted at edge t is presented on out_valid after edge t+1; 1 beat/cycle throughput.
// Backpressure: W holds payload while out_ready is low, E then fills, in_ready drops; flush empties both stages.
// Ports: clock/reset/flush; in_* upstream beat; alu_* to the ALU, alu_out back; out_* write-back beat; flags.
module ula_exec_stage
    import lapido_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int RA_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_wen,
    output logic [3:0]        out_flags,
    output logic              out_illegal,
    output logic [3:0]        flags
);

    logic            e_valid;
    logic            w_valid;
    logic [RA_W-1:0] e_rd;
    logic            e_wen;
    logic            out_fire;
    logic            w_free;
    logic            e_adv;
    logic            in_fire;
    logic [4:0]      e_op;
    logic            e_legal;
    logic [3:0]      e_flags;

    // A flush cycle never presents a beat, so it can never hand off or touch flags
    assign out_valid = w_valid && !flush;
    assign out_fire  = out_valid && out_ready;
    assign w_free    = !w_valid || out_fire;
    assign e_adv     = e_valid && w_free;
    assign in_ready  = !flush && (!e_valid || e_adv);
    assign in_fire   = in_valid && in_ready;

    assign e_op    = 5'(alu_opcode);
    assign e_legal = is_legal_op(e_op);

    ula_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .a      (alu_a),
        .b      (alu_b),
        .opcode (e_op),
        .res    (alu_out),
        .nzcv   (e_flags)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            e_valid     <= 1'b0;
            w_valid     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            e_rd        <= '0;
            e_wen       <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
            flags       <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
            w_valid <= 1'b0;
        end else begin
            // ALU operands only move when a new beat lands in E
            if (in_fire) begin
                e_valid    <= 1'b1;
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_opcode <= in_opcode;
                e_rd       <= in_rd;
                e_wen      <= in_wen;
            end else if (e_adv) begin
                e_valid <= 1'b0;
            end

            if (e_adv) begin
                w_valid     <= 1'b1;
                out_result  <= e_legal ? alu_out : '0;
                out_rd      <= e_rd;
                out_wen     <= e_legal && e_wen;
                out_flags   <= e_legal ? e_flags : 4'b0000;
                out_illegal <= !e_legal;
            end else if (out_fire) begin
                w_valid <= 1'b0;
            end

            if (out_fire && !out_illegal) begin
                flags <= out_flags;
            end
        end
    end

endmodule
